// File: rtl/ifu_sa_cache.sv
// rtl/ifu_sa_cache.sv - set-associative IFU instruction cache with per-set tree-PLRU and miss FSM
// Optional macro IFU_CACHE_PERF_EN adds saturating hit/miss counters.
module ifu_sa_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 4,
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8),
  localparam int SET_BITS     = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 0,
  localparam int LADDR_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH,
  localparam int TAG_WIDTH    = LADDR_WIDTH - SET_BITS
) (
  input  logic                   Clock,
  input  logic                   Rst_n,
  input  logic                   cpu_reqValidIn,
  input  logic [ADDR_WIDTH-1:0]  cpu_reqAddrIn,
  output logic                   cpu_reqReadyOut,
  output logic                   cpu_rspValidOut,
  output logic [ADDR_WIDTH-1:0]  cpu_rspAddrOut,
  output logic [LINE_WIDTH-1:0]  cpu_rspInsLineOut,
  output logic                   mem_reqValidOut,
  output logic [LADDR_WIDTH-1:0] mem_reqAddrOut,
  input  logic                   mem_reqReadyIn,
  input  logic                   mem_rspValidIn,
  input  logic [LADDR_WIDTH-1:0] mem_rspAddrIn,
  input  logic [LINE_WIDTH-1:0]  mem_rspInsLineIn,
  input  logic                   flushIn,
  output logic                   hitStatusOut,
  output logic [31:0]            perf_hitCntOut,
  output logic [31:0]            perf_missCntOut
);

  localparam int SET_W = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} state_t;

  state_t                              state;
  logic [ADDR_WIDTH-1:0]               req_addr_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0]   plru_q;
  logic [TAG_WIDTH-1:0]                tag_mem  [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0]               data_mem [NUM_SETS][NUM_WAYS];
  logic                                flush_pending;
  logic                                mem_req_valid_q;
  logic                                rsp_valid_q;
  logic [LINE_WIDTH-1:0]               rsp_line_q;

  logic [SET_W-1:0]       set_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [LADDR_WIDTH-1:0] req_laddr;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [WAY_W-1:0]       victim_way;
  logic                   lookup_hit;
  logic                   fill_match;

  generate
    if (SET_BITS > 0) begin : g_set
      assign set_idx = req_addr_q[OFFSET_WIDTH +: SET_W];
    end else begin : g_noset
      assign set_idx = '0;
    end
  endgenerate

  assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_laddr = req_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH];

  // Walk the heap-ordered tree: each node bit selects lower (0) or upper (1) child.
  function automatic logic [WAY_W-1:0] plru_pick(input logic [NUM_WAYS-2:0] tree);
    int node = 0;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + 1 + int'(tree[node]);
    return WAY_W'(node - (NUM_WAYS - 1));
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] tree,
                                                     input logic [WAY_W-1:0] way);
    int   node = 0;
    logic b;
    logic [NUM_WAYS-2:0] t;
    t = tree;
    for (int l = 0; l < WAY_W; l++) begin
      b = way[WAY_W-1-l];
      t[node] = ~b;
      node = 2 * node + 1 + int'(b);
    end
    return t;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_mem[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Invalid ways take priority over the PLRU choice; descending loop leaves the lowest.
  always_comb begin
    victim_way = plru_pick(plru_q[set_idx]);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) victim_way = WAY_W'(w);
    end
  end

  assign lookup_hit = (state == LOOKUP) && hit;
  assign fill_match = (state == MISS_WAIT) && mem_rspValidIn && (mem_rspAddrIn == req_laddr);

  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      state           <= IDLE;
      req_addr_q      <= '0;
      valid_q         <= '0;
      plru_q          <= '0;
      flush_pending   <= 1'b0;
      mem_req_valid_q <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_line_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (flushIn && (state != IDLE)) flush_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (flushIn || flush_pending) begin
            valid_q       <= '0;
            plru_q        <= '0;
            flush_pending <= 1'b0;
          end else if (cpu_reqValidIn) begin
            req_addr_q <= cpu_reqAddrIn;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
            state           <= IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            state           <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_reqReadyIn) begin
            mem_req_valid_q <= 1'b0;
            state           <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (fill_match) begin
            valid_q[set_idx][victim_way] <= 1'b1;
            plru_q[set_idx]              <= plru_touch(plru_q[set_idx], victim_way);
            rsp_line_q                   <= mem_rspInsLineIn;
            rsp_valid_q                  <= 1'b1;
            state                        <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (fill_match) begin
      tag_mem[set_idx][victim_way]  <= req_tag;
      data_mem[set_idx][victim_way] <= mem_rspInsLineIn;
    end
  end

  assign cpu_reqReadyOut   = (state == IDLE) && !flush_pending && !flushIn;
  assign cpu_rspValidOut   = lookup_hit || rsp_valid_q;
  assign cpu_rspAddrOut    = req_addr_q;
  assign cpu_rspInsLineOut = lookup_hit ? data_mem[set_idx][hit_way] : rsp_line_q;
  assign mem_reqValidOut   = mem_req_valid_q;
  assign mem_reqAddrOut    = req_laddr;
  assign hitStatusOut      = lookup_hit;

`ifdef IFU_CACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == LOOKUP) begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hitCntOut  = hit_cnt_q;
  assign perf_missCntOut = miss_cnt_q;
`else
  assign perf_hitCntOut  = '0;
  assign perf_missCntOut = '0;
`endif

endmodule

// File: tb/tb_ifu_sa_cache.sv
// tb/tb_ifu_sa_cache.sv - directed table-driven bench for ifu_sa_cache (4 sets, 4 ways, 128-bit lines)
module tb_ifu_sa_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_addr;
  logic [127:0] rsp_line;
  logic         mem_req_valid;
  logic [27:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [27:0]  mem_rsp_addr;
  logic [127:0] mem_rsp_line;
  logic         flush;
  logic         hit_status;
  logic [31:0]  perf_hit;
  logic [31:0]  perf_miss;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifu_sa_cache dut (
    .Clock(clk), .Rst_n(rst_n),
    .cpu_reqValidIn(req_valid), .cpu_reqAddrIn(req_addr), .cpu_reqReadyOut(req_ready),
    .cpu_rspValidOut(rsp_valid), .cpu_rspAddrOut(rsp_addr), .cpu_rspInsLineOut(rsp_line),
    .mem_reqValidOut(mem_req_valid), .mem_reqAddrOut(mem_req_addr), .mem_reqReadyIn(mem_req_ready),
    .mem_rspValidIn(mem_rsp_valid), .mem_rspAddrIn(mem_rsp_addr), .mem_rspInsLineIn(mem_rsp_line),
    .flushIn(flush), .hitStatusOut(hit_status),
    .perf_hitCntOut(perf_hit), .perf_missCntOut(perf_miss)
  );

  typedef struct {
    bit           is_flush;
    logic [31:0]  addr;
    bit           hit;
    logic [127:0] line;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkline(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1357_9BDF};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 1'b1);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_addr"}, rsp_addr, 32'h0);
    check({tag, "_rsp_line"}, rsp_line, 128'h0);
    check({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 28'h0);
    check({tag, "_hit"}, hit_status, 1'b0);
    check({tag, "_perf_hit"}, perf_hit, 32'h0);
    check({tag, "_perf_miss"}, perf_miss, 32'h0);
  endtask

  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic do_req(input string tag, input logic [31:0] a, input bit exp_hit,
                        input logic [127:0] line, input int stall, input bit bogus,
                        input bit flush_mid);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    @(negedge clk);
    check({tag, "_lookup_hit"}, hit_status, exp_hit);
    check({tag, "_lookup_rsp_valid"}, rsp_valid, exp_hit);
    if (exp_hit) begin
      check({tag, "_hit_line"}, rsp_line, line);
      check({tag, "_hit_addr"}, rsp_addr, a);
      check({tag, "_hit_no_memreq"}, mem_req_valid, 1'b0);
      tick();
      return;
    end
    tick();
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check($sformatf("%s_stall%0d_valid", tag, i), mem_req_valid, 1'b1);
      check($sformatf("%s_stall%0d_addr", tag, i), mem_req_addr, a[31:4]);
      tick();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    check({tag, "_memreq_valid"}, mem_req_valid, 1'b1);
    check({tag, "_memreq_addr"}, mem_req_addr, a[31:4]);
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check({tag, "_wait_memreq_low"}, mem_req_valid, 1'b0);
    check({tag, "_wait_rsp_low"}, rsp_valid, 1'b0);
    if (flush_mid) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    if (bogus) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_addr  = 28'h999;
      mem_rsp_line  = ~line;
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check({tag, "_bogus_rsp_low"}, rsp_valid, 1'b0);
      check({tag, "_bogus_busy"}, req_ready, 1'b0);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_addr  = a[31:4];
    mem_rsp_line  = line;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check({tag, "_resp_valid"}, rsp_valid, 1'b1);
    check({tag, "_resp_line"}, rsp_line, line);
    check({tag, "_resp_addr"}, rsp_addr, a);
    check({tag, "_resp_hit_low"}, hit_status, 1'b0);
    tick();
    if (flush_mid) begin
      @(negedge clk);
      check({tag, "_pending_flush_ready"}, req_ready, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [127:0] a5;
    logic [31:0]  exp_h;
    logic [31:0]  exp_m;
    a5 = {16{8'hA5}};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_addr = '0; mem_rsp_line = '0; flush = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Cold miss/hit, flush racing a request, then PLRU replacement in set 0.
    tbl.push_back('{1'b0, 32'h0000_1000, 1'b0, a5});
    tbl.push_back('{1'b0, 32'h0000_1000, 1'b1, a5});
    tbl.push_back('{1'b1, 32'h0000_1000, 1'b0, '0});
    tbl.push_back('{1'b0, 32'h0000_1000, 1'b0, a5});
    tbl.push_back('{1'b1, 32'h0000_0000, 1'b0, '0});
    tbl.push_back('{1'b0, 32'h0000_0000, 1'b0, mkline(32'h000)});
    tbl.push_back('{1'b0, 32'h0000_0040, 1'b0, mkline(32'h040)});
    tbl.push_back('{1'b0, 32'h0000_0080, 1'b0, mkline(32'h080)});
    tbl.push_back('{1'b0, 32'h0000_00C0, 1'b0, mkline(32'h0C0)});
    tbl.push_back('{1'b0, 32'h0000_0000, 1'b1, mkline(32'h000)});
    tbl.push_back('{1'b0, 32'h0000_0100, 1'b0, mkline(32'h100)});
    tbl.push_back('{1'b0, 32'h0000_0040, 1'b1, mkline(32'h040)});
    tbl.push_back('{1'b0, 32'h0000_0080, 1'b0, mkline(32'h080)});
    tbl.push_back('{1'b0, 32'h0000_00C0, 1'b0, mkline(32'h0C0)});
    tbl.push_back('{1'b0, 32'h0000_0100, 1'b1, mkline(32'h100)});
    tbl.push_back('{1'b0, 32'h0000_0000, 1'b0, mkline(32'h000)});
    tbl.push_back('{1'b0, 32'h0000_0080, 1'b1, mkline(32'h080)});
    tbl.push_back('{1'b0, 32'h0000_0040, 1'b0, mkline(32'h040)});
    tbl.push_back('{1'b0, 32'h0000_0050, 1'b0, mkline(32'h050)});
    tbl.push_back('{1'b0, 32'h0000_0050, 1'b1, mkline(32'h050)});

    foreach (tbl[i]) begin
      if (tbl[i].is_flush) begin
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = tbl[i].addr;
        @(negedge clk);
        check($sformatf("row%0d_flush_ready", i), req_ready, 1'b0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check($sformatf("row%0d_post_flush_ready", i), req_ready, 1'b1);
        check($sformatf("row%0d_post_flush_rsp", i), rsp_valid, 1'b0);
        tick();
      end else begin
        do_req($sformatf("row%0d", i), tbl[i].addr, tbl[i].hit, tbl[i].line, 0, 1'b0, 1'b0);
      end
    end

    do_req("stall", 32'h0000_5020, 1'b0, mkline(32'h5020), 5, 1'b1, 1'b0);
    do_req("stall_hit", 32'h0000_5020, 1'b1, mkline(32'h5020), 0, 1'b0, 1'b0);

    do_req("fmid", 32'h0000_7030, 1'b0, mkline(32'h7030), 0, 1'b0, 1'b1);
    do_req("fmid_re", 32'h0000_7030, 1'b0, mkline(32'h7031), 0, 1'b0, 1'b0);
    do_req("fmid_other", 32'h0000_5020, 1'b0, mkline(32'h5020), 0, 1'b0, 1'b0);

    // Reset while waiting for fill data; the late fill must not produce a response.
    req_valid = 1'b1;
    req_addr  = 32'h0000_8000;
    tick();
    req_valid = 1'b0;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_wait");
    tick();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_addr  = 28'h800;
    mem_rsp_line  = mkline(32'h8000);
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_late_rsp%0d", i), rsp_valid, 1'b0);
      check($sformatf("rst_late_ready%0d", i), req_ready, 1'b1);
      tick();
    end
    do_req("rst_re", 32'h0000_8000, 1'b0, mkline(32'h8001), 0, 1'b0, 1'b0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_req("perf0", 32'h0000_2000, 1'b0, mkline(32'h2000), 0, 1'b0, 1'b0);
    do_req("perf1", 32'h0000_2000, 1'b1, mkline(32'h2000), 0, 1'b0, 1'b0);
    do_req("perf2", 32'h0000_3010, 1'b0, mkline(32'h3010), 0, 1'b0, 1'b0);
    do_req("perf3", 32'h0000_3010, 1'b1, mkline(32'h3010), 0, 1'b0, 1'b0);
    do_req("perf4", 32'h0000_4000, 1'b0, mkline(32'h4000), 0, 1'b0, 1'b0);
`ifdef IFU_CACHE_PERF_EN
    exp_h = 32'd2;
    exp_m = 32'd3;
`else
    exp_h = 32'd0;
    exp_m = 32'd0;
`endif
    @(negedge clk);
    check("perf_hit", perf_hit, exp_h);
    check("perf_miss", perf_miss, exp_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
